drr_sched: RTL
==============

DRR_SCHED -- requirements
Module: drr_sched

Interface
REQ-001 Parameter NUM_FIFO, default 3, meaning number of input queues scheduled (2..16).
REQ-002 Parameter SEL_WIDTH, default $clog2(NUM_FIFO), meaning width of the queue index.
REQ-003 Parameter LEN_WIDTH, default 16, meaning width of the packet length in bytes and of each quantum.
REQ-004 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 Port fifo_tvalid, input, NUM_FIFO, meaning bit i = queue i has a head packet or beat available.
REQ-007 Port fifo_tlast, input, NUM_FIFO, meaning bit i = the current beat of queue i is the last beat of its packet.
REQ-008 Port fifo_len, input, NUM_FIFO*LEN_WIDTH, meaning slice i = byte length of the head packet of queue i, valid when fifo_tvalid[i] is high.
REQ-009 Port quantum, input, NUM_FIFO*LEN_WIDTH, meaning slice i = DRR quantum of queue i in bytes; the value 0 disables queue i.
REQ-010 Port out_tready, input, 1, meaning the downstream mux output accepts a beat.
REQ-011 Port sel_out, output, SEL_WIDTH, meaning index of the granted queue, which drives the mux select.
REQ-012 Port en_out, output, 1, meaning grant active; high for exactly the duration of one packet transfer.
REQ-013 Port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, ADD, CHECK and SEND.
REQ-015 Per-queue deficit counters SHALL be LEN_WIDTH+1 bits wide, and each addition to them SHALL saturate at all-ones.
REQ-016 In IDLE, when |fifo_tvalid is high, the FSM SHALL move to ADD on the next edge, with the round-robin pointer ptr unchanged.
REQ-017 In ADD, if fifo_tvalid[ptr]=1 and quantum[ptr]!=0, then deficit[ptr] += quantum[ptr] and the FSM moves to CHECK.
REQ-018 In ADD, if fifo_tvalid[ptr]=0 or quantum[ptr]=0, then deficit[ptr] <= 0, ptr advances (wrapping from NUM_FIFO-1 to 0), and the FSM stays in ADD.
REQ-019 In ADD, when fifo_tvalid is all zero, the FSM SHALL return to IDLE with the deficits left unchanged.
REQ-020 In CHECK, if fifo_tvalid[ptr]=1 and fifo_len[ptr] <= deficit[ptr], then deficit[ptr] -= fifo_len[ptr], sel_out <= ptr, en_out <= 1, and the FSM moves to SEND.
REQ-021 In CHECK, if fifo_tvalid[ptr]=0, then deficit[ptr] <= 0, ptr advances, and the FSM moves to ADD.
REQ-022 In CHECK, if fifo_len[ptr] > deficit[ptr], the deficit is kept, ptr advances, and the FSM moves to ADD.
REQ-023 In SEND, sel_out SHALL be held constant.
REQ-024 In SEND, on the cycle where fifo_tvalid[sel_out] & fifo_tlast[sel_out] & out_tready is true, en_out <= 0 and the FSM moves to CHECK with ptr unchanged, so the same queue may send again.
REQ-025 fifo_tlast bits of non-granted queues SHALL be ignored.
REQ-026 The grant latency, from IDLE with a single eligible queue whose deficit already covers its packet, SHALL be 3 edges (IDLE->ADD->CHECK->SEND).
REQ-027 A length of 0 SHALL be treated as eligible whenever the queue is valid.
REQ-028 Changes to the quantum SHALL take effect at the next ADD visit; deficits are never recomputed retroactively.
REQ-029 sel_out SHALL only change on the CHECK->SEND transition.
REQ-030 en_out SHALL never be high outside SEND.

Reset
REQ-031 While rst_n=0, outputs and state SHALL be cleared immediately (asynchronously): state=IDLE, ptr=0, all deficits=0, sel_out=0, en_out=0, busy=0.
REQ-032 A reset asserted during SEND SHALL drop en_out at once; the partially sent packet is not tracked after reset.
REQ-033 Deassertion of rst_n SHALL be synchronised externally; after deassertion the first state transition SHALL occur on the next rising edge of clk.

Verification
REQ-034 Scenario, single queue: quantum0=100, queue 0 holds one 100-byte packet, others empty -> en_out rises 3 edges after tvalid, sel_out=0, deficit0=0 after grant, IDLE after tlast.
REQ-035 Scenario, fairness: quanta all 500, queues 0/1 continuously backlogged with 300-byte packets -> grant order 0,1,0,0,1,1,... and 1:1 byte share over 30 packets ±1 packet.
REQ-036 Scenario, weighting: quantum0=1000, quantum1=250, 250-byte packets -> 4 grants of q0 per grant of q1.
REQ-037 Scenario, empty reset: q2 becomes empty in CHECK with deficit=80 -> deficit2=0, and the next visit starts from the quantum only.
REQ-038 Scenario, backpressure: out_tready low for 10 cycles mid-packet, tlast on q1 asserted -> en_out stays 1 and sel_out stays constant until the tlast handshake.
REQ-039 Scenario, async reset mid-SEND: rst_n pulled low between clock edges -> en_out=0 and sel_out=0 before the next edge; after release, a fresh grant to queue 0 if it is valid.

Source files
------------

// File: rtl/drr_sched.sv
// Deficit round-robin packet scheduler: picks which input queue drives the
// downstream mux, one whole packet per grant, with per-queue byte quanta.
module drr_sched #(
   parameter int NUM_FIFO  = 3,
   parameter int SEL_WIDTH = $clog2(NUM_FIFO),
   parameter int LEN_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_FIFO-1:0]           fifo_tvalid,
   input  logic [NUM_FIFO-1:0]           fifo_tlast,
   input  logic [NUM_FIFO*LEN_WIDTH-1:0] fifo_len,
   input  logic [NUM_FIFO*LEN_WIDTH-1:0] quantum,
   input  logic                          out_tready,
   output logic [SEL_WIDTH-1:0]          sel_out,
   output logic                          en_out,
   output logic                          busy
);

   localparam int DEF_WIDTH = LEN_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, ADD, CHECK, SEND} state_t;

   state_t               state;
   logic [SEL_WIDTH-1:0] ptr;
   logic [DEF_WIDTH-1:0] deficit [NUM_FIFO];

   logic [LEN_WIDTH-1:0] cur_len;
   logic [LEN_WIDTH-1:0] cur_quantum;
   logic [DEF_WIDTH-1:0] cur_def;
   logic                 cur_valid;
   logic                 cur_fits;
   logic                 sel_done;
   logic [SEL_WIDTH-1:0] ptr_next;

   // Deficit grows by one quantum per visit; clamp rather than wrap.
   function automatic logic [DEF_WIDTH-1:0] sat_add(input logic [DEF_WIDTH-1:0] a,
                                                    input logic [LEN_WIDTH-1:0] b);
      logic [DEF_WIDTH:0] s;
      s = {1'b0, a} + {2'b00, b};
      return s[DEF_WIDTH] ? '1 : s[DEF_WIDTH-1:0];
   endfunction

   always_comb begin
      cur_len     = '0;
      cur_quantum = '0;
      cur_def     = '0;
      cur_valid   = 1'b0;
      for (int i = 0; i < NUM_FIFO; i++) begin
         if (ptr == SEL_WIDTH'(i)) begin
            cur_len     = fifo_len[i*LEN_WIDTH +: LEN_WIDTH];
            cur_quantum = quantum[i*LEN_WIDTH +: LEN_WIDTH];
            cur_def     = deficit[i];
            cur_valid   = fifo_tvalid[i];
         end
      end
   end

   assign cur_fits = ({1'b0, cur_len} <= cur_def);
   assign ptr_next = (ptr == SEL_WIDTH'(NUM_FIFO - 1)) ? '0 : ptr + 1'b1;
   // Only the granted queue's tlast can end the transfer.
   assign sel_done = fifo_tvalid[sel_out] & fifo_tlast[sel_out] & out_tready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         sel_out <= '0;
         en_out  <= 1'b0;
         for (int i = 0; i < NUM_FIFO; i++) deficit[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|fifo_tvalid) state <= ADD;
            end
            ADD: begin
               if (!(|fifo_tvalid)) begin
                  state <= IDLE;
               end else if (cur_valid && (cur_quantum != '0)) begin
                  deficit[ptr] <= sat_add(cur_def, cur_quantum);
                  state        <= CHECK;
               end else begin
                  deficit[ptr] <= '0;
                  ptr          <= ptr_next;
               end
            end
            CHECK: begin
               if (cur_valid && cur_fits) begin
                  deficit[ptr] <= cur_def - {1'b0, cur_len};
                  sel_out      <= ptr;
                  en_out       <= 1'b1;
                  state        <= SEND;
               end else begin
                  // An emptied queue forfeits its credit; a short one keeps it.
                  if (!cur_valid) deficit[ptr] <= '0;
                  ptr   <= ptr_next;
                  state <= ADD;
               end
            end
            SEND: begin
               if (sel_done) begin
                  en_out <= 1'b0;
                  state  <= CHECK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
